// File: rtl/mem_access_unit_if.sv
// Request, data-memory and writeback signals of the load/store unit.
// A transfer on req_* or wb_* happens at a rising edge where valid && ready;
// the offering side holds valid and its payload stable until that edge.
interface mem_access_unit_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic             req_size;
  logic             req_signed;
  logic [18:0]      req_addr;
  logic [18:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic [18:0]      mem_A;
  logic [18:0]      mem_WD;
  logic             mem_WE;
  logic             mem_Cant_Byte;
  logic             mem_reset_n;
  logic [18:0]      mem_RD;
  logic             wb_valid;
  logic             wb_ready;
  logic [18:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic [7:0]       split_cnt;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag,
    input  mem_RD, wb_ready,
    output req_ready, mem_A, mem_WD, mem_WE, mem_Cant_Byte, mem_reset_n,
    output wb_valid, wb_data, wb_tag, split_cnt
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag,
    output mem_RD, wb_ready,
    input  req_ready, mem_A, mem_WD, mem_WE, mem_Cant_Byte, mem_reset_n,
    input  wb_valid, wb_data, wb_tag, split_cnt
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/halfword accesses to a byte-wide memory, splitting
// misaligned halfwords into two byte accesses and extending load results.
module mem_access_unit #(
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_access_unit_if.slave       bus,
  output logic [1:0]             fsm_state
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC1 = 2'd1;
  localparam logic [1:0] ACC2 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic             we_q, size_q, signed_q, split_q;
  logic [18:0]      addr_q, wdata_q;
  logic [TAG_W-1:0] tag_q;
  logic [15:0]      result_q;
  logic [7:0]       split_cnt_q;
  logic             hs, req_split;
  logic             unused_rd;

  assign hs        = bus.req_valid && bus.req_ready;
  assign req_split = bus.req_size && bus.req_addr[0];
  assign unused_rd = ^bus.mem_RD[18:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      signed_q    <= 1'b0;
      split_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      split_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            we_q     <= bus.req_we;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            split_q  <= req_split;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            tag_q    <= bus.req_tag;
            state    <= ACC1;
            if (req_split && split_cnt_q != 8'hFF)
              split_cnt_q <= split_cnt_q + 8'd1;
          end
        end
        ACC1: begin
          // Split loads keep only the low byte here; ACC2 supplies the high byte.
          if (!we_q)
            result_q <= (split_q || !size_q) ? {8'h00, bus.mem_RD[7:0]} : bus.mem_RD[15:0];
          if (split_q)   state <= ACC2;
          else if (we_q) state <= IDLE;
          else           state <= DONE;
        end
        ACC2: begin
          if (!we_q)
            result_q[15:8] <= bus.mem_RD[7:0];
          state <= we_q ? IDLE : DONE;
        end
        default: begin
          if (bus.wb_ready)
            state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_A         = '0;
    bus.mem_WD        = '0;
    bus.mem_WE        = 1'b0;
    bus.mem_Cant_Byte = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_data       = '0;
    bus.wb_tag        = '0;
    case (state)
      ACC1: begin
        bus.mem_A         = addr_q;
        bus.mem_Cant_Byte = size_q && !split_q;
        bus.mem_WD        = split_q ? {11'b0, wdata_q[7:0]} : wdata_q;
        bus.mem_WE        = we_q;
      end
      ACC2: begin
        bus.mem_A  = addr_q + 19'd1;
        bus.mem_WD = {11'b0, wdata_q[15:8]};
        bus.mem_WE = we_q;
      end
      DONE: begin
        bus.wb_valid = 1'b1;
        bus.wb_tag   = tag_q;
        if (size_q)
          bus.wb_data = {(signed_q ? {3{result_q[15]}} : 3'b000), result_q};
        else
          bus.wb_data = {(signed_q ? {11{result_q[7]}} : 11'b0), result_q[7:0]};
      end
      default: ;
    endcase
  end

  assign bus.req_ready   = (state == IDLE) && !reset;
  assign bus.mem_reset_n = ~reset;
  assign bus.split_cnt   = split_cnt_q;
  assign fsm_state       = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a little-endian byte memory model.
module tb_mem_access_unit;
  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;
  int         n_checks;
  int         n_errors;

  logic [7:0]  mem [0:524287];
  logic        poke_en;
  logic [18:0] poke_a;
  logic [7:0]  poke_d;
  logic [18:0] a_next;

  mem_access_unit_if #(.TAG_W(4)) bus ();

  mem_access_unit #(.TAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge.
  assign a_next = bus.mem_A + 19'd1;
  assign bus.mem_RD = bus.mem_Cant_Byte ? {3'b0, mem[a_next], mem[bus.mem_A]}
                                        : {11'b0, mem[bus.mem_A]};
  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (bus.mem_WE) begin
      mem[bus.mem_A] <= bus.mem_WD[7:0];
      if (bus.mem_Cant_Byte) mem[a_next] <= bus.mem_WD[15:8];
    end
  end

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [18:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  // Offers one request; returns just after the handshake edge (unit in ACC1).
  task automatic issue(input logic we, input logic size, input logic sgn,
                       input logic [18:0] addr, input logic [18:0] wdata,
                       input logic [3:0] tag);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_tag    = tag;
    @(negedge clk);
    chk("req_ready_before_hs", {18'b0, bus.req_ready}, 19'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    poke_en        = 1'b0;
    poke_a         = '0;
    poke_d         = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_tag    = '0;
    bus.wb_ready   = 1'b1;

    poke(19'h00011, 8'h80);
    poke(19'h7FFFF, 8'h34);
    poke(19'h00000, 8'h92);
    poke(19'h00100, 8'h01);
    poke(19'h00101, 8'h80);
    poke(19'h00021, 8'hCC);
    poke(19'h00022, 8'hAA);

    @(negedge clk);
    chk("rst_req_ready", {18'b0, bus.req_ready}, 19'd0);
    chk("rst_mem_WE", {18'b0, bus.mem_WE}, 19'd0);
    chk("rst_wb_valid", {18'b0, bus.wb_valid}, 19'd0);
    chk("rst_split_cnt", {11'b0, bus.split_cnt}, 19'd0);
    chk("rst_mem_reset_n", {18'b0, bus.mem_reset_n}, 19'd0);
    chk("rst_mem_A", bus.mem_A, 19'd0);
    reset = 1'b0;
    #1;
    chk("rel_req_ready", {18'b0, bus.req_ready}, 19'd1);
    chk("rel_mem_reset_n", {18'b0, bus.mem_reset_n}, 19'd1);

    // Aligned signed byte load at 0x00011, byte 0x80.
    issue(1'b0, 1'b0, 1'b1, 19'h00011, 19'h0, 4'd5);
    @(negedge clk);
    chk("ld8_acc1_A", bus.mem_A, 19'h00011);
    chk("ld8_acc1_cb", {18'b0, bus.mem_Cant_Byte}, 19'd0);
    chk("ld8_acc1_WE", {18'b0, bus.mem_WE}, 19'd0);
    chk("ld8_acc1_wbv", {18'b0, bus.wb_valid}, 19'd0);
    @(negedge clk);
    chk("ld8_wbv", {18'b0, bus.wb_valid}, 19'd1);
    chk("ld8_data", bus.wb_data, 19'h7FF80);
    chk("ld8_tag", {15'b0, bus.wb_tag}, 19'd5);
    chk("ld8_rdy_low", {18'b0, bus.req_ready}, 19'd0);
    @(negedge clk);
    chk("ld8_rdy_back", {18'b0, bus.req_ready}, 19'd1);
    chk("ld8_wbv_clr", {18'b0, bus.wb_valid}, 19'd0);

    // Misaligned halfword store 0xBEEF at 0x00003.
    issue(1'b1, 1'b1, 1'b0, 19'h00003, 19'h0BEEF, 4'd0);
    @(negedge clk);
    chk("st16s_acc1_A", bus.mem_A, 19'h00003);
    chk("st16s_acc1_WD", bus.mem_WD, 19'h000EF);
    chk("st16s_acc1_WE", {18'b0, bus.mem_WE}, 19'd1);
    chk("st16s_acc1_cb", {18'b0, bus.mem_Cant_Byte}, 19'd0);
    chk("st16s_cnt", {11'b0, bus.split_cnt}, 19'd1);
    @(negedge clk);
    chk("st16s_acc2_A", bus.mem_A, 19'h00004);
    chk("st16s_acc2_WD", bus.mem_WD, 19'h000BE);
    chk("st16s_acc2_WE", {18'b0, bus.mem_WE}, 19'd1);
    chk("st16s_acc2_rdy", {18'b0, bus.req_ready}, 19'd0);
    @(negedge clk);
    chk("st16s_rdy_back", {18'b0, bus.req_ready}, 19'd1);
    chk("st16s_no_wbv", {18'b0, bus.wb_valid}, 19'd0);
    chk("st16s_mem3", {11'b0, mem[3]}, 19'h000EF);
    chk("st16s_mem4", {11'b0, mem[4]}, 19'h000BE);

    // Aligned halfword store 0x1234 at 0x00200: one busy cycle.
    issue(1'b1, 1'b1, 1'b0, 19'h00200, 19'h01234, 4'd0);
    @(negedge clk);
    chk("st16a_cb", {18'b0, bus.mem_Cant_Byte}, 19'd1);
    chk("st16a_WD", bus.mem_WD, 19'h01234);
    chk("st16a_WE", {18'b0, bus.mem_WE}, 19'd1);
    @(negedge clk);
    chk("st16a_rdy_back", {18'b0, bus.req_ready}, 19'd1);
    chk("st16a_mem", {3'b0, mem[19'h00201], mem[19'h00200]}, 19'h01234);

    // Unsigned halfword load across the top of the address space.
    issue(1'b0, 1'b1, 1'b0, 19'h7FFFF, 19'h0, 4'd9);
    @(negedge clk);
    chk("ldw_acc1_A", bus.mem_A, 19'h7FFFF);
    chk("ldw_acc1_cb", {18'b0, bus.mem_Cant_Byte}, 19'd0);
    @(negedge clk);
    chk("ldw_acc2_A", bus.mem_A, 19'h00000);
    chk("ldw_acc2_WE", {18'b0, bus.mem_WE}, 19'd0);
    chk("ldw_acc2_wbv", {18'b0, bus.wb_valid}, 19'd0);
    @(negedge clk);
    chk("ldw_wbv", {18'b0, bus.wb_valid}, 19'd1);
    chk("ldw_data", bus.wb_data, 19'h09234);
    chk("ldw_tag", {15'b0, bus.wb_tag}, 19'd9);
    chk("ldw_cnt", {11'b0, bus.split_cnt}, 19'd2);

    // Signed aligned halfword load 0x8001 with writeback stalled.
    issue(1'b0, 1'b1, 1'b1, 19'h00100, 19'h0, 4'd3);
    bus.wb_ready = 1'b0;
    @(negedge clk);
    chk("ld16_acc1_cb", {18'b0, bus.mem_Cant_Byte}, 19'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wbv", {18'b0, bus.wb_valid}, 19'd1);
      chk("stall_data", bus.wb_data, 19'h78001);
      chk("stall_tag", {15'b0, bus.wb_tag}, 19'd3);
      chk("stall_rdy", {18'b0, bus.req_ready}, 19'd0);
      chk("stall_WE", {18'b0, bus.mem_WE}, 19'd0);
      chk("stall_A", bus.mem_A, 19'd0);
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk("stall_rdy_back", {18'b0, bus.req_ready}, 19'd1);

    // Reset in the middle of ACC1 of a split store.
    issue(1'b1, 1'b1, 1'b0, 19'h00021, 19'h05566, 4'd0);
    @(negedge clk);
    chk("rs_acc1_WE", {18'b0, bus.mem_WE}, 19'd1);
    chk("rs_cnt_pre", {11'b0, bus.split_cnt}, 19'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_WE_drop", {18'b0, bus.mem_WE}, 19'd0);
    chk("rs_A_zero", bus.mem_A, 19'd0);
    chk("rs_WD_zero", bus.mem_WD, 19'd0);
    chk("rs_cnt_zero", {11'b0, bus.split_cnt}, 19'd0);
    chk("rs_rdy_low", {18'b0, bus.req_ready}, 19'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rs_mem21", {11'b0, mem[19'h00021]}, 19'h000CC);
    chk("rs_mem22", {11'b0, mem[19'h00022]}, 19'h000AA);
    reset = 1'b0;
    #1;
    chk("rs_rdy_back", {18'b0, bus.req_ready}, 19'd1);

    // Unit still works after the abort: unsigned byte load at 0x00021.
    issue(1'b0, 1'b0, 1'b0, 19'h00021, 19'h0, 4'd7);
    @(negedge clk);
    @(negedge clk);
    chk("post_wbv", {18'b0, bus.wb_valid}, 19'd1);
    chk("post_data", bus.wb_data, 19'h000CC);
    chk("post_tag", {15'b0, bus.wb_tag}, 19'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of destination-register tag.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  load/store request offered by execute stage.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  1  0 = byte, 1 = halfword.
REQ-008 SHALL have port req_signed  input  1  load sign-extension enable.
REQ-009 SHALL have port req_addr  input  19  byte address.
REQ-010 SHALL have port req_wdata  input  19  store data; bits [15:0] used.
REQ-011 SHALL have port req_tag  input  TAG_W  destination register of a load.
REQ-012 SHALL have port mem_A  output  19  data-memory byte address.
REQ-013 SHALL have port mem_WD  output  19  data-memory write data.
REQ-014 SHALL have port mem_WE  output  1  data-memory write enable.
REQ-015 SHALL have port mem_Cant_Byte  output  1  0 = byte access, 1 = halfword access.
REQ-016 SHALL have port mem_reset_n  output  1  equals ~reset; drives the memory's active-low reset.
REQ-017 SHALL have port mem_RD  input  19  combinational read data from data memory (zero-extended).
REQ-018 SHALL have port wb_valid  output  1  load result available.
REQ-019 SHALL have port wb_ready  input  1  writeback stage accepts result.
REQ-020 SHALL have ports wb_data  output  19  and wb_tag  output  TAG_W  load result and its tag.
REQ-021 SHALL have port split_cnt  output  8  saturating count of misaligned halfword accesses.

Function
REQ-022 SHALL implement states IDLE, ACC1, ACC2, DONE.
REQ-023 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready at a rising edge, capturing all req_* fields into registers and moving to ACC1.
REQ-024 SHALL classify a request as split when req_size=1 and req_addr[0]=1; all other requests are single.
REQ-025 SHALL in ACC1 drive mem_A = captured addr; mem_Cant_Byte = size for single, 0 for split; mem_WD = wdata (single) or {11'b0, wdata[7:0]} (split); mem_WE = store flag.
REQ-026 SHALL in ACC2 drive mem_A = addr+1 (19-bit wrap, 7FFFF -> 00000), mem_Cant_Byte=0, mem_WD = {11'b0, wdata[15:8]}, mem_WE = store flag.
REQ-027 SHALL hold mem_WE=0 in IDLE and DONE; mem_A, mem_WD, mem_Cant_Byte SHALL be 0 in those states.
REQ-028 SHALL on ACC1 exit capture mem_RD[7:0] (byte or split low byte) or mem_RD[15:0] (single halfword) for loads.
REQ-029 SHALL on ACC2 exit capture mem_RD[7:0] as result bits [15:8] of a split load.
REQ-030 SHALL transition ACC1 -> ACC2 if split, else ACC1 -> DONE for loads, ACC1 -> IDLE for stores; ACC2 -> DONE for loads, IDLE for stores.
REQ-031 SHALL in DONE assert wb_valid with wb_data = result sign-extended from bit 7 (byte) or bit 15 (halfword) when signed flag set, else zero-extended; wb_tag = captured tag.
REQ-032 SHALL hold wb_valid, wb_data, wb_tag stable until wb_valid && wb_ready, then return to IDLE; req_ready SHALL not rise before that edge.
REQ-033 SHALL increment split_cnt once per accepted split request at the handshake edge, saturating at 8'hFF.
REQ-034 SHALL produce latency: aligned load wb_valid 2 cycles after handshake; split load 3 cycles; aligned store busy 1 cycle, split store 2 cycles.
REQ-035 SHALL never issue a memory write for a load and never assert wb_valid for a store.

Reset
REQ-036 SHALL on reset assertion immediately (asynchronously) enter IDLE, abort any in-flight access without completing ACC2, and force mem_WE=0, wb_valid=0, wb_data=0, wb_tag=0, split_cnt=0, mem_A/mem_WD/mem_Cant_Byte=0; req_ready=0 while reset high, 1 on first cycle after release.

Verification
REQ-037 SHALL cover: aligned signed byte load at 0x00011 with mem byte 0x80 -> wb_valid 2 cycles later, wb_data=0x7FF80.
REQ-038 SHALL cover: halfword store 0xBEEF at 0x00003 -> ACC1 byte write 0xEF at 0x00003, ACC2 byte write 0xBE at 0x00004, split_cnt=1, req_ready back after 2 cycles.
REQ-039 SHALL cover: unsigned halfword load at 0x7FFFF -> second access at 0x00000, wb_data = {3'b0, byte@0, byte@7FFFF}.
REQ-040 SHALL cover: wb_ready held low 5 cycles -> wb_valid/wb_data stable, req_ready low, no memory activity.
REQ-041 SHALL cover: reset asserted mid-cycle in ACC1 of split store -> mem_WE drops same cycle, no ACC2 write occurs, split_cnt=0.
